// File: rtl/axis_frame_pkg.sv
// Shared types and sizing helpers for the AXIS frame packer.
package axis_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PAD  = 2'd2
    } state_t;

    localparam int FRAME_BEATS_DEF  = 64;
    localparam int IDLE_TIMEOUT_DEF = 1024;

    function automatic int beat_idx_width(input int frame_beats);
        return (frame_beats <= 2) ? 1 : $clog2(frame_beats);
    endfunction

    function automatic int idle_cnt_width(input int idle_timeout);
        return $clog2(idle_timeout + 1);
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Generic 2-entry registered AXIS slice; the head entry drives the outputs directly.
module axis_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             full,
    output logic             full_next,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    logic [WIDTH-1:0] tail_q;
    logic             tail_vld;
    logic             deq, enq;
    logic [1:0]       occ, occ_next;

    assign deq       = out_valid & out_ready;
    assign enq       = in_valid & (~full | deq);
    assign full      = out_valid & tail_vld;
    assign occ       = {1'b0, out_valid} + {1'b0, tail_vld};
    assign occ_next  = occ + {1'b0, enq} - {1'b0, deq};
    assign full_next = (occ_next == 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            tail_q    <= '0;
            tail_vld  <= 1'b0;
        end else if (deq) begin
            if (tail_vld) begin
                out_data <= tail_q;
                if (enq) tail_q <= in_data;
                else     tail_vld <= 1'b0;
            end else if (enq) begin
                out_data <= in_data;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (enq) begin
            // Head is held stable while stalled; a second beat lands in the tail.
            if (!out_valid) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else begin
                tail_q   <= in_data;
                tail_vld <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_frame_packer.sv
// Cuts a merged AXIS stream into fixed-length frames with TLAST, zero-padding
// a partial frame once the input has been idle for IDLE_TIMEOUT cycles.
module axis_frame_packer
    import axis_frame_pkg::*;
#(
    parameter int DATA_WIDTH   = 512,
    parameter int FRAME_BEATS  = FRAME_BEATS_DEF,
    parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] AXIS_IN_TDATA,
    input  logic                  AXIS_IN_TVALID,
    output logic                  AXIS_IN_TREADY,
    output logic [DATA_WIDTH-1:0] AXIS_OUT_TDATA,
    output logic                  AXIS_OUT_TVALID,
    output logic                  AXIS_OUT_TLAST,
    input  logic                  AXIS_OUT_TREADY,
    output logic [CNT_WIDTH-1:0]  frames_out,
    output logic [CNT_WIDTH-1:0]  pad_beats,
    output logic                  pad_active
);
    localparam int BW = beat_idx_width(FRAME_BEATS);
    localparam int IW = idle_cnt_width(IDLE_TIMEOUT);
    localparam int SW = DATA_WIDTH + 2;
    localparam logic [BW-1:0] LAST_IDX   = BW'(FRAME_BEATS - 1);
    localparam logic [IW-1:0] TIMEOUT_M1 = IW'(IDLE_TIMEOUT - 1);

    state_t                state, state_next;
    logic [BW-1:0]         beat_idx, beat_idx_next;
    logic [IW-1:0]         idle_cnt, idle_cnt_next;
    logic                  in_ready;
    logic                  buf_full, buf_full_next;
    logic                  in_hs, pad_enq, enq, is_last;
    logic [DATA_WIDTH-1:0] enq_data;
    logic [SW-1:0]         enq_word, out_word;
    logic                  out_valid, out_hs;

    assign AXIS_IN_TREADY = in_ready;
    assign in_hs    = AXIS_IN_TVALID & in_ready;
    assign pad_enq  = (state == PAD) & ~buf_full;
    assign enq      = in_hs | pad_enq;
    assign is_last  = (beat_idx == LAST_IDX);
    assign enq_data = pad_enq ? {DATA_WIDTH{1'b0}} : AXIS_IN_TDATA;
    // Entry layout: {pad_tag, last, data}.
    assign enq_word = {pad_enq, is_last, enq_data};

    axis_skid_buffer #(.WIDTH(SW)) u_skid (
        .clk       (clk),
        .rst_n     (resetn),
        .in_data   (enq_word),
        .in_valid  (enq),
        .full      (buf_full),
        .full_next (buf_full_next),
        .out_data  (out_word),
        .out_valid (out_valid),
        .out_ready (AXIS_OUT_TREADY)
    );

    assign AXIS_OUT_TVALID = out_valid;
    assign AXIS_OUT_TDATA  = out_word[DATA_WIDTH-1:0];
    assign AXIS_OUT_TLAST  = out_word[DATA_WIDTH];
    assign out_hs          = out_valid & AXIS_OUT_TREADY;
    assign pad_active      = (state == PAD);

    always_comb begin
        state_next    = state;
        beat_idx_next = beat_idx;
        idle_cnt_next = idle_cnt;
        if (enq) beat_idx_next = is_last ? '0 : beat_idx + BW'(1);
        case (state)
            IDLE: begin
                idle_cnt_next = '0;
                if (enq) state_next = FILL;
            end
            FILL: begin
                if (enq && is_last) begin
                    state_next    = IDLE;
                    idle_cnt_next = '0;
                end else if (AXIS_IN_TVALID) begin
                    idle_cnt_next = '0;
                end else begin
                    idle_cnt_next = idle_cnt + IW'(1);
                    if (idle_cnt == TIMEOUT_M1) state_next = PAD;
                end
            end
            PAD: begin
                if (pad_enq && is_last) begin
                    state_next    = IDLE;
                    idle_cnt_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            beat_idx   <= '0;
            idle_cnt   <= '0;
            in_ready   <= 1'b0;
            frames_out <= '0;
            pad_beats  <= '0;
        end else begin
            state    <= state_next;
            beat_idx <= beat_idx_next;
            idle_cnt <= idle_cnt_next;
            // Ready is computed for the coming cycle so it can leave a flop.
            in_ready <= ~buf_full_next & (state_next != PAD);
            if (out_hs && out_word[DATA_WIDTH])   frames_out <= frames_out + CNT_WIDTH'(1);
            if (out_hs && out_word[DATA_WIDTH+1]) pad_beats  <= pad_beats + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_axis_frame_packer.sv
// Randomized scoreboard bench for axis_frame_packer with a frame-level reference model.
module tb_axis_frame_packer;
    localparam int DW = 32;
    localparam int FB = 4;
    localparam int TO = 16;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready = 1'b1;
    logic [CW-1:0] frames_out;
    logic [CW-1:0] pad_beats;
    logic          pad_active;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    beat_t         mon_b;
    int            total = 0;
    int            bad = 0;
    int            frame_pos = 0;
    int            exp_frames = 0;
    int            exp_pads = 0;
    int            rdy_mode = 0;
    int            out_count = 0;
    int            cnt_snap;
    bit            pad_seen = 1'b0;
    bit            stalled = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    axis_frame_packer #(
        .DATA_WIDTH  (DW),
        .FRAME_BEATS (FB),
        .IDLE_TIMEOUT(TO),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .AXIS_IN_TDATA  (in_data),
        .AXIS_IN_TVALID (in_valid),
        .AXIS_IN_TREADY (in_ready),
        .AXIS_OUT_TDATA (out_data),
        .AXIS_OUT_TVALID(out_valid),
        .AXIS_OUT_TLAST (out_last),
        .AXIS_OUT_TREADY(out_ready),
        .frames_out     (frames_out),
        .pad_beats      (pad_beats),
        .pad_active     (pad_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: beats are numbered within a frame; the last slot carries TLAST.
    task automatic push_exp(input logic [DW-1:0] d);
        beat_t b;
        b.data = d;
        b.last = (frame_pos == FB - 1);
        exp_q.push_back(b);
        if (b.last) exp_frames++;
        frame_pos = (frame_pos + 1) % FB;
    endtask

    task automatic expect_pad();
        while (frame_pos != 0) begin
            exp_pads++;
            push_exp('0);
        end
    endtask

    task automatic send(input logic [DW-1:0] d);
        int waited = 0;
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        while (!ok && waited < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        in_valid = 1'b0;
        check("send_handshake", 64'(ok), 64'd1);
        if (ok) push_exp(d);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain_and_count(input string name);
        int w = 0;
        while (exp_q.size() != 0 && w < 5000) begin
            @(posedge clk);
            #1;
            w++;
        end
        check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
        idle(2);
        check({name, "_frames_out"}, 64'(frames_out), 64'(exp_frames));
        check({name, "_pad_beats"}, 64'(pad_beats), 64'(exp_pads));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_in_ready"}, 64'(in_ready), 64'd0);
        check({name, "_out_valid"}, 64'(out_valid), 64'd0);
        check({name, "_out_last"}, 64'(out_last), 64'd0);
        check({name, "_out_data"}, 64'(out_data), 64'd0);
        check({name, "_frames_out"}, 64'(frames_out), 64'd0);
        check({name, "_pad_beats"}, 64'(pad_beats), 64'd0);
        check({name, "_pad_active"}, 64'(pad_active), 64'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!resetn) begin
            stalled = 1'b0;
        end else begin
            if (pad_active) begin
                pad_seen = 1'b1;
                check("pad_in_ready_low", 64'(in_ready), 64'd0);
            end
            if (stalled) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", 64'(out_data), 64'(prev_data));
                check("stall_last", 64'(out_last), 64'(prev_last));
            end
            if (out_valid && out_ready) begin
                out_count++;
                check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    mon_b = exp_q.pop_front();
                    check("out_data", 64'(out_data), 64'(mon_b.data));
                    check("out_last", 64'(out_last), 64'(mon_b.last));
                end
            end
            stalled   = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
        end
    end

    initial begin
        #2 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        resetn = 1'b1;
        idle(2);

        // Continuous stream of 8 beats, full throughput.
        send(32'd1);
        check("latency_valid", 64'(out_valid), 64'd1);
        check("latency_data", 64'(out_data), 64'd1);
        for (int i = 2; i <= 8; i++) send(DW'(i));
        drain_and_count("stream8");

        // Partial frame padded after the idle timeout.
        pad_seen = 1'b0;
        send(32'hA);
        send(32'hB);
        send(32'hC);
        expect_pad();
        idle(40);
        drain_and_count("pad");
        check("pad_active_seen", 64'(pad_seen), 64'd1);

        // One cycle short of the timeout: no padding.
        pad_seen = 1'b0;
        send(32'h11);
        idle(TO - 1);
        send(32'h22);
        send(32'h33);
        send(32'h44);
        drain_and_count("no_pad");
        check("no_pad_active", 64'(pad_seen), 64'd0);

        // Random backpressure and short input gaps.
        rdy_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            send($urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 10));
        end
        rdy_mode = 0;
        drain_and_count("random");

        // Long idle with no open frame.
        pad_seen = 1'b0;
        cnt_snap = out_count;
        idle(5000);
        check("idle_no_output", 64'(out_count), 64'(cnt_snap));
        check("idle_no_pad", 64'(pad_seen), 64'd0);

        // Asynchronous reset mid-frame with the buffer full.
        rdy_mode = 2;
        idle(3);
        send(32'h55);
        send(32'h66);
        idle(2);
        check("prereset_valid", 64'(out_valid), 64'd1);
        check("prereset_full_ready", 64'(in_ready), 64'd0);
        #2 resetn = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        frame_pos  = 0;
        exp_frames = 0;
        exp_pads   = 0;
        rdy_mode   = 0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(1);
        send(32'h101);
        send(32'h102);
        send(32'h103);
        send(32'h104);
        drain_and_count("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
